mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch stage (read-only, word fetches) and the data-memory stage (loads/stores).
- Sits between both pipeline stages and the memory model. It registers the winning command, holds it on the memory port until the memory signals completion, then returns read data and a one-cycle done pulse to the owner.
- Data-memory requests have priority. A starvation counter guarantees fetch progress, and a fetch flush (taken jump) discards an in-flight fetch response.

Parameters:
- ADDR_L, 32, width of all address buses.
- DATA_L, 32, width of all data buses.
- STARVE_MAX, 3, consecutive data-memory grants, taken while fetch is waiting, after which fetch wins the next tie (1..15).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  ADDR_L  fetch address, sampled at grant.
- if_flush  in  1  fetch redirect, one cycle pulse or level.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_L  fetched word, holds until next fetch completes.
- dm_req  in  1  data request, level, held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_L  data address, sampled at grant.
- dm_wdata  in  DATA_L  store data, sampled at grant.
- dm_len  in  2  access length code, passed through.
- dm_done  out  1  one-cycle pulse; dm_rdata valid for loads.
- dm_rdata  out  DATA_L  load data, holds until next load completes.
- mem_req  out  1  memory command valid, held until mem_ready.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_L  memory address.
- mem_wdata  out  DATA_L  memory write data.
- mem_len  out  2  length code; fetch always drives 3.
- mem_ready  in  1  memory completion, 1 cycle; may rise in the same cycle mem_req first rises.
- mem_rdata  in  DATA_L  read data, valid with mem_ready.

Behaviour:
- Reset (synchronous):
  - state IDLE, owner none, starve counter 0, discard flag 0.
  - All outputs 0, including rdata registers and mem_* buses.
  - Reset during BUSY: mem_req is 0 after the edge. A later mem_ready is ignored and no done pulse is produced.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - Eligible requesters are dm_req=1 and (if_req=1 and if_flush=0).
  - Winner selection:
    - dm only: dm wins.
    - if only: if wins.
    - Both: if wins when starve==STARVE_MAX, otherwise dm wins.
  - At the edge, latch the winner's command into mem_*: fetch gives we=0 and len=3. Set mem_req=1, record owner, go to BUSY.
  - Starve counter:
    - Incremented (saturating at STARVE_MAX) on a dm grant while if_req=1.
    - Cleared on an if grant, or on a dm grant while if_req=0.
  - No eligible requester: stay IDLE, mem_req=0.
- BUSY:
  - mem_* held stable.
  - if_flush=1 while owner=if sets the discard flag. if_flush has no effect when owner=dm.
  - On mem_ready=1 at the edge: mem_req<=0. Go to DONE.
    - owner=dm: dm_done<=1; dm_rdata<=mem_rdata only when dm_we=0.
    - owner=if and discard=0: if_done<=1, if_rdata<=mem_rdata.
    - owner=if and discard=1 (flag was already set, or if_flush=1 in this cycle): no done pulse and no rdata update.
- DONE:
  - The done pulse is high for exactly this cycle.
  - The requesters are ignored in this cycle. A requester must drop req at the edge ending the done cycle.
  - Clear the discard flag and the done outputs, then go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_req at cycle 1.
  - mem_ready at cycle k≥1 gives done at cycle k+1 and IDLE at k+2.
  - With zero-wait memory, back-to-back accesses from one requester are 3 cycles apart.
- mem_ready in IDLE or DONE is ignored.
- Only one access is outstanding at any time. The block performs no address or length checking.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x1000, memory returns 0x8C220004 with mem_ready in the same cycle mem_req rises.
  - Required: mem_req cycle 1 with addr=0x1000, we=0, len=3; if_done and if_rdata=0x8C220004 at cycle 2; idle at cycle 3.
- Store with wait states:
  - Stimulus: dm_req, we=1, addr=0x2004, wdata=0xDEADBEEF, len=3; mem_ready 4 cycles after mem_req.
  - Required: mem_* stable for 4 cycles; dm_done pulses once; dm_rdata stays 0.
- Contention:
  - Stimulus: both req held, each re-requesting immediately after done, STARVE_MAX=3.
  - Required: grant order dm, dm, dm, if, dm, dm, dm, if.
- Flush in flight:
  - Stimulus: fetch at 0x1008, if_flush in BUSY, then fetch at 0x2000.
  - Required: no if_done for 0x1008 and if_rdata unchanged; the next fetch completes normally.
- Flush in IDLE:
  - Stimulus: if_flush=1 with if_req=1 in IDLE, dm_req=0.
  - Required: no grant that cycle; grant the following cycle.
- Reset mid-access:
  - Stimulus: rst in BUSY, then mem_ready.
  - Required: mem_req=0 after the edge, no done pulse, starve counter 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data memory
// Data memory has priority; a starvation counter lets fetch win a tie after STARVE_MAX dm grants.
module mem_port_arbiter #(
  parameter int ADDR_L     = 32,
  parameter int DATA_L     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_L-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_L-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_L-1:0] dm_addr,
  input  logic [DATA_L-1:0] dm_wdata,
  input  logic [1:0]        dm_len,
  output logic              dm_done,
  output logic [DATA_L-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_L-1:0] mem_addr,
  output logic [DATA_L-1:0] mem_wdata,
  output logic [1:0]        mem_len,
  input  logic              mem_ready,
  input  logic [DATA_L-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;
  logic [3:0]        starve_q, starve_d;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_L-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_L-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_len_q, mem_len_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_L-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_L-1:0] dm_rdata_q, dm_rdata_d;

  logic if_elig, grant_if, grant_dm;

  // A flushed fetch is not eligible; fetch only wins a tie once the starve count saturates.
  assign if_elig  = if_req & ~if_flush;
  assign grant_if = if_elig & (~dm_req | (starve_q == STARVE_LIM));
  assign grant_dm = dm_req & ~grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_dm_q  <= 1'b0;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_len_q   <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      starve_q    <= starve_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_if | grant_dm) state_d = S_BUSY;
      S_BUSY:  if (mem_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_dm_d  = owner_dm_q;
    starve_d    = starve_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_len_d   = mem_len_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_len_d   = dm_len;
          owner_dm_d  = 1'b1;
          if (!if_req)                    starve_d = '0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
        end else if (grant_if) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_len_d   = 2'd3;
          owner_dm_d  = 1'b0;
          starve_d    = '0;
        end
      end
      S_BUSY: begin
        if (!owner_dm_q && if_flush) discard_d = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (owner_dm_q) begin
            dm_done_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end else if (!(discard_q | if_flush)) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      S_DONE: discard_d = 1'b0;
      default: ;
    endcase
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_len   = mem_len_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [1:0]  dm_len = '0;
  logic        if_done, dm_done, mem_req, mem_we, mem_ready;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_len;

  logic        model_ready = 1'b0;
  logic        manual_ready = 1'b0;
  int          wait_n = 0;
  int          mem_cnt = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  len;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] ifd_q[$];
  logic [31:0] dmd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_len(dm_len),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h8C22_0004;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign mem_ready = model_ready | manual_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [1:0] len);
    cmd_t c;
    c.addr = a; c.we = we; c.wdata = wd; c.len = len;
    cmd_q.push_back(c);
  endtask

  task automatic wait_done(input bit is_if, input string name);
    int t = 0;
    while (!(is_if ? if_done : dm_done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, (t < 100), 1'b1);
  endtask

  // Memory model: asserts ready after wait_n extra cycles of mem_req
  always @(negedge clk) begin
    if (mem_req) begin
      if (mem_cnt >= wait_n) begin
        model_ready = 1'b1;
        mem_cnt = 0;
      end else begin
        model_ready = 1'b0;
        mem_cnt++;
      end
    end else begin
      model_ready = 1'b0;
      mem_cnt = 0;
    end
  end

  logic prev_req = 1'b0;
  cmd_t cur;
  always @(negedge clk) begin
    cmd_t e;
    if (mem_req && !prev_req) begin
      if (cmd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL grant_unexpected: got addr %h expected no grant", mem_addr);
      end else begin
        e = cmd_q.pop_front();
        check("grant_addr", mem_addr, e.addr);
        check("grant_we", mem_we, e.we);
        check("grant_len", mem_len, e.len);
        if (e.we) check("grant_wdata", mem_wdata, e.wdata);
      end
      cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata; cur.len = mem_len;
    end else if (mem_req && prev_req) begin
      check("mem_stable_addr", mem_addr, cur.addr);
      check("mem_stable_wdata", mem_wdata, cur.wdata);
      check("mem_stable_ctl", {mem_we, mem_len}, {cur.we, cur.len});
    end
    prev_req = mem_req;
    if (if_done) begin
      if (ifd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL if_done_unexpected: got if_done=1 rdata %h expected no done", if_rdata);
      end else check("if_rdata", if_rdata, ifd_q.pop_front());
    end
    if (dm_done) begin
      if (dmd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dm_done_unexpected: got dm_done=1 rdata %h expected no done", dm_rdata);
      end else check("dm_rdata", dm_rdata, dmd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, seen, t;
    repeat (2) @(negedge clk);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_bus", {mem_we, mem_len, mem_addr, mem_wdata}, 0);
    check("reset_dones", {if_done, dm_done}, 0);
    check("reset_rdata", if_rdata | dm_rdata, 0);
    rst = 1'b0;

    // Single fetch, zero-wait memory
    @(negedge clk);
    wait_n = 0;
    if_addr = 32'h1000; if_req = 1'b1;
    push_cmd(32'h1000, 1'b0, 32'h0, 2'd3);
    ifd_q.push_back(32'h8C22_0004);
    @(negedge clk);
    check("fetch_req_cycle1", mem_req, 1);
    @(negedge clk);
    check("fetch_done_cycle2", if_done, 1);
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_idle_cycle3", {mem_req, if_done}, 0);

    // Store with four wait states
    @(negedge clk);
    wait_n = 4;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_len = 2'd3;
    push_cmd(32'h2004, 1'b1, 32'hDEAD_BEEF, 2'd3);
    dmd_q.push_back(32'h0);
    hi = 0; t = 0;
    while (!dm_done && t < 100) begin
      @(negedge clk);
      if (mem_req) hi++;
      t++;
    end
    check("store_done_seen", dm_done, 1);
    check("store_busy_cycles", hi, 5);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check("store_single_pulse", dm_done, 0);

    // Flush while a fetch is in flight
    wait_n = 3;
    if_addr = 32'h1008; if_req = 1'b1;
    push_cmd(32'h1008, 1'b0, 32'h0, 2'd3);
    @(negedge clk);
    check("flush_fetch_granted", mem_req, 1);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    if_addr = 32'h2000;
    push_cmd(32'h2000, 1'b0, 32'h0, 2'd3);
    ifd_q.push_back(32'h5A5A_2000);
    repeat (3) @(negedge clk);
    check("flush_no_done", if_done, 0);
    check("flush_rdata_kept", if_rdata, 32'h8C22_0004);
    check("flush_port_released", mem_req, 0);
    wait_done(1'b1, "refetch_done");
    if_req = 1'b0;

    // Flush in IDLE blocks the grant for one cycle
    @(negedge clk);
    wait_n = 0;
    if_addr = 32'h3000; if_req = 1'b1; if_flush = 1'b1;
    push_cmd(32'h3000, 1'b0, 32'h0, 2'd3);
    ifd_q.push_back(32'h5A5A_3000);
    @(negedge clk);
    check("idle_flush_no_grant", mem_req, 0);
    if_flush = 1'b0;
    @(negedge clk);
    check("idle_flush_grant_next", mem_req, 1);
    wait_done(1'b1, "idle_flush_done");
    if_req = 1'b0;

    // Contention: grant order dm,dm,dm,if,dm,dm,dm,if
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        push_cmd(32'h200, 1'b0, 32'h1234_5678, 2'd2);
        dmd_q.push_back(32'h5A5A_0200);
      end
      push_cmd(32'h100, 1'b0, 32'h0, 2'd3);
      ifd_q.push_back(32'h5A5A_0100);
    end
    dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h1234_5678; dm_len = 2'd2; dm_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    seen = 0; t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      if (if_done) seen++;
      t++;
    end
    check("contention_if_dones", seen, 2);
    dm_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("contention_grants_drained", cmd_q.size(), 0);

    // Reset during BUSY
    wait_n = 50;
    dm_addr = 32'h200; dm_req = 1'b1; if_req = 1'b1;
    push_cmd(32'h200, 1'b0, 32'h0, 2'd2);
    @(negedge clk);
    check("rst_busy_req", mem_req, 1);
    check("starve_before_reset", dut.starve_q, 1);
    @(negedge clk);
    rst = 1'b1; dm_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_starve", dut.starve_q, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    rst = 1'b0;
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    check("rst_no_done_a", {if_done, dm_done}, 0);
    @(negedge clk);
    check("rst_no_done_b", {if_done, dm_done}, 0);

    check("cmd_q_empty", cmd_q.size(), 0);
    check("ifd_q_empty", ifd_q.size(), 0);
    check("dmd_q_empty", dmd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
